fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage with an IF/ID pipeline register. It keeps the fetch PC and issues one request at a time to instruction memory over a valid/ready request channel and a valid-only response channel. It presents `{id_pc, id_inst, id_valid}` to the decode stage (register file, immediate extender, control). It honours decode-stage stalls and branch/jump redirects, and drops any response that becomes stale.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `NOP_INST`, default `32'h0000_0013`: value driven on `id_inst` when the IF/ID register is flushed or empty (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `redirect_valid` in 1: branch/jump taken; refetch from `redirect_pc`.
- `redirect_pc` in 32: redirect target; bits [1:0] must be 0.
- `stall` in 1: decode cannot accept; hold IF/ID contents.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_addr` out 32: fetch address.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_rsp_valid` in 1: response data valid; at most one per accepted request, earliest one cycle after the request is accepted.
- `imem_rsp_data` in 32: fetched instruction.
- `id_valid` out 1: IF/ID holds a valid instruction.
- `id_pc` out 32: PC of `id_inst`.
- `id_inst` out 32: instruction to decode.

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - `inflight_pc`: address of the outstanding request.
  - One-entry hold buffer: `hold_pc`, `hold_inst`.
  - IF/ID register: `id_valid`, `id_pc`, `id_inst`.
  - FSM state.
- FSM states are REQ, WAIT, HOLD and DROP.
  - REQ: `imem_req_valid`=1, `imem_req_addr`=`fetch_pc`. When `imem_req_ready`=1, the request is accepted: `inflight_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+4 (mod 2^32), go to WAIT.
  - WAIT: when `imem_rsp_valid`=1 and the IF/ID slot is free (`id_valid`=0 or `stall`=0), load IF/ID with {`inflight_pc`, `imem_rsp_data`} and `id_valid`<=1, go to REQ. If `imem_rsp_valid`=1 but the slot is not free, capture into the hold buffer and go to HOLD.
  - HOLD: when `stall`=0, move the hold buffer into IF/ID (`id_valid`<=1) and go to REQ.
  - DROP: a stale request is outstanding. Discard the response when `imem_rsp_valid`=1, then go to REQ.
- Consumption: if `id_valid`=1, `stall`=0 and nothing loads this cycle, then `id_valid`<=0 and `id_inst`<=`NOP_INST`.
- Redirect has priority over everything except `rst`:
  - `fetch_pc`<=`redirect_pc`.
  - Flush IF/ID: `id_valid`<=0, `id_inst`<=`NOP_INST`.
  - Clear the hold buffer.
  - Next state:
    - REQ with `imem_req_ready`=1 goes to DROP. The handshake with the old address still happens, and `fetch_pc` takes `redirect_pc`, not +4.
    - REQ without ready stays in REQ and requests `redirect_pc` next cycle.
    - WAIT without `imem_rsp_valid` goes to DROP.
    - WAIT with `imem_rsp_valid` discards the data and goes to REQ.
    - HOLD goes to REQ.
    - DROP with `imem_rsp_valid` goes to REQ; otherwise it stays in DROP.
- Redirect and stall in the same cycle: the redirect wins and IF/ID is flushed.
- Alignment: `redirect_pc[1:0]`≠0 is illegal input. No checking is done.

## Timing
- Reset values:
  - state REQ, `fetch_pc`=`RESET_PC`.
  - `imem_req_valid`=1 in the first cycle after reset, with `imem_req_addr`=`RESET_PC`.
  - `id_valid`=0, `id_pc`=`RESET_PC`, `id_inst`=`NOP_INST`.
  - Hold buffer cleared.
- `imem_req_valid` and `imem_req_addr` are decoded from registered state only. There is no combinational path from any input.
- `id_*` are registered outputs.
- Latency: with zero-wait memory (request accepted cycle t, response t+1), `id_valid` rises at t+2. Peak throughput is one instruction per 2 cycles.
- `rst` mid-transaction abandons the outstanding request. A response arriving after reset is ignored because the FSM is in REQ.
- `id_pc` holds its value while `id_valid`=0.

## Test plan
- Reset, then zero-wait memory with `imem_rsp_data`=addr^`32'hA5A5_0000`: the ID stream carries `id_pc` 0x0, 0x4, 0x8, 0xC with matching data, and `id_valid` pulses every 2nd cycle.
- Stall at the instant of the response for pc 0x8, held 3 cycles: the instruction is captured in HOLD and no new request is issued. `id_pc`=0x4 stays valid during the stall. After release, 0x8 appears with no loss or duplication.
- `redirect_valid` with `redirect_pc`=0x100 while in WAIT, with the response delayed 2 cycles: the stale response is dropped and `id_valid`=0 throughout. The next request address is 0x100, and `id_pc`=0x100 arrives later.
- Redirect in REQ in the same cycle as `imem_req_ready`: the old request is accepted but its response is dropped. `fetch_pc` becomes 0x200, not old+4.
- Redirect and stall asserted together with `id_valid`=1: `id_valid`=0 and `id_inst`=0x13 the next cycle.
- `rst` asserted in WAIT, with the response arriving the cycle after reset: the response is ignored, the first request is to 0x0, and all outputs show their reset values.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with an IF/ID pipeline register.
// Issues one instruction-memory request at a time. A one-entry hold buffer
// absorbs a response that arrives while decode is stalled. Redirects discard
// any request that is still outstanding.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request fetch_pc
    S_WAIT = 2'd1,  // request accepted, waiting for its response
    S_HOLD = 2'd2,  // response parked in the hold buffer while decode stalls
    S_DROP = 2'd3   // outstanding response is stale and will be discarded
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_inflight_pc;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_inst;
  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;

  logic w_slot_free;
  logic w_accept;
  logic w_load_rsp;
  logic w_capture_hold;
  logic w_load_hold;

  // IF/ID can take a new instruction when it is empty or being consumed.
  assign w_slot_free = !r_id_valid || !stall;

  // Request channel decoded from registered state only.
  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_fetch_pc;

  assign id_valid = r_id_valid;
  assign id_pc    = r_id_pc;
  assign id_inst  = r_id_inst;

  // Next-state decode and the per-cycle datapath strobes.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    w_next_state   = r_state;
    w_accept       = 1'b0;
    w_load_rsp     = 1'b0;
    w_capture_hold = 1'b0;
    w_load_hold    = 1'b0;
    case (r_state)
      S_REQ: begin
        if (imem_req_ready) begin
          // The handshake completes even on a redirect; its response is then stale.
          w_accept     = 1'b1;
          w_next_state = redirect_valid ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_next_state = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          if (w_slot_free) begin
            w_load_rsp   = 1'b1;
            w_next_state = S_REQ;
          end else begin
            w_capture_hold = 1'b1;
            w_next_state   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_next_state = S_REQ;
        end else if (!stall) begin
          w_load_hold  = 1'b1;
          w_next_state = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) w_next_state = S_REQ;
      end
      default: w_next_state = S_REQ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) r_state <= S_REQ;
    else     r_state <= w_next_state;
  end

  // Fetch PC and the address of the outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= RESET_PC;
    end else begin
      if (w_accept) r_inflight_pc <= r_fetch_pc;
      if (redirect_valid) r_fetch_pc <= redirect_pc;
      else if (w_accept)  r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  // One-entry hold buffer for a response that decode cannot yet accept.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      r_hold_pc   <= '0;
      r_hold_inst <= '0;
    end else if (w_capture_hold) begin
      r_hold_pc   <= r_inflight_pc;
      r_hold_inst <= imem_rsp_data;
    end
  end

  // IF/ID register: flush on redirect, load, or empty on consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= RESET_PC;
      r_id_inst  <= NOP_INST;
    end else if (redirect_valid) begin
      r_id_valid <= 1'b0;
      r_id_inst  <= NOP_INST;
    end else if (w_load_rsp) begin
      r_id_valid <= 1'b1;
      r_id_pc    <= r_inflight_pc;
      r_id_inst  <= imem_rsp_data;
    end else if (w_load_hold) begin
      r_id_valid <= 1'b1;
      r_id_pc    <= r_hold_pc;
      r_id_inst  <= r_hold_inst;
    end else if (r_id_valid && !stall) begin
      r_id_valid <= 1'b0;
      r_id_inst  <= NOP_INST;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. Inputs change and outputs are sampled
// on the falling edge; a small memory responder answers accepted requests
// with addr ^ 32'hA5A5_0000 after a programmable number of extra cycles.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int errors = 0;
  int checks = 0;

  // Memory responder state (driven only from tasks).
  bit          mem_auto;
  int          rsp_delay;
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_wait;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wire [97:0] w_obs = {imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst};

  function automatic logic [97:0] exp_t(input logic rv, input logic [31:0] ra,
                                        input logic iv, input logic [31:0] pc,
                                        input logic [31:0] inst);
    return {rv, ra, iv, pc, inst};
  endfunction

  function automatic string fmt(input logic [97:0] v);
    return $sformatf("req_valid=%0b req_addr=%h id_valid=%0b id_pc=%h id_inst=%h",
                     v[97], v[96:65], v[64], v[63:32], v[31:0]);
  endfunction

  // Advance one cycle: note a handshake at the coming edge, then at the next
  // falling edge present any due response for one cycle.
  task automatic step();
    if (mem_auto && !rst && imem_req_valid && imem_req_ready) begin
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      pend_wait = rsp_delay;
    end
    @(negedge clk);
    if (mem_auto) begin
      imem_rsp_valid = 1'b0;
      if (pend) begin
        if (pend_wait == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = pend_addr ^ KEY;
          pend           = 1'b0;
        end else begin
          pend_wait--;
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend           = 1'b0;
    mem_auto       = 1'b1;
    rsp_delay      = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [97:0] e;
    rst            = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hFFFF_FFFF;
    mem_auto       = 1'b0;
    step();
    step();
    e = exp_t(1'b1, 32'h0, 1'b0, 32'h0, NOP);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL reset_values: got %s want %s", fmt(w_obs), fmt(e));
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_ra[8] = '{32'h4, 32'h4, 32'h8, 32'h8, 32'hC, 32'hC, 32'h10, 32'h10};
    logic [31:0] exp_pc[8] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'hC};
    logic [97:0] e;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      // id_valid and req_valid are high on every second cycle
      e = exp_t(i[0], exp_ra[i], i[0], exp_pc[i], i[0] ? (exp_pc[i] ^ KEY) : NOP);
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL zero_wait[%0d]: got %s want %s", i, fmt(w_obs), fmt(e));
      end
    end
  endtask

  task automatic test_stall_hold();
    logic [97:0] e;
    apply_reset();
    for (int i = 0; i < 4; i++) step();
    e = exp_t(1'b1, 32'h8, 1'b1, 32'h4, 32'hA5A5_0004);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL stall_pre: got %s want %s", fmt(w_obs), fmt(e));
    end
    stall = 1'b1;
    // 0x8 accepted, its response lands in the hold buffer, no new request
    for (int i = 0; i < 3; i++) begin
      step();
      e = exp_t(1'b0, 32'hC, 1'b1, 32'h4, 32'hA5A5_0004);
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL stall_held[%0d]: got %s want %s", i, fmt(w_obs), fmt(e));
      end
    end
    stall = 1'b0;
    step();
    e = exp_t(1'b1, 32'hC, 1'b1, 32'h8, 32'hA5A5_0008);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL stall_release: got %s want %s", fmt(w_obs), fmt(e));
    end
    step();
    e = exp_t(1'b0, 32'h10, 1'b0, 32'h8, NOP);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL stall_no_dup: got %s want %s", fmt(w_obs), fmt(e));
    end
    step();
    e = exp_t(1'b1, 32'h10, 1'b1, 32'hC, 32'hA5A5_000C);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL stall_next: got %s want %s", fmt(w_obs), fmt(e));
    end
  endtask

  task automatic test_redirect_wait();
    logic [97:0] e;
    apply_reset();
    rsp_delay = 2;
    step();
    e = exp_t(1'b0, 32'h4, 1'b0, 32'h0, NOP);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rdw_wait: got %s want %s", fmt(w_obs), fmt(e));
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    // stale response is presented during the second of these cycles
    for (int i = 0; i < 2; i++) begin
      e = exp_t(1'b0, 32'h100, 1'b0, 32'h0, NOP);
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL rdw_drop[%0d]: got %s want %s", i, fmt(w_obs), fmt(e));
      end
      step();
    end
    e = exp_t(1'b1, 32'h100, 1'b0, 32'h0, NOP);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rdw_newreq: got %s want %s", fmt(w_obs), fmt(e));
    end
    rsp_delay = 0;
    step();
    step();
    e = exp_t(1'b1, 32'h104, 1'b1, 32'h100, 32'hA5A5_0100);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rdw_arrive: got %s want %s", fmt(w_obs), fmt(e));
    end
  endtask

  task automatic test_redirect_req_ready();
    logic [97:0] e;
    apply_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    e = exp_t(1'b0, 32'h200, 1'b0, 32'h0, NOP);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rdr_drop: got %s want %s", fmt(w_obs), fmt(e));
    end
    step();
    e = exp_t(1'b1, 32'h200, 1'b0, 32'h0, NOP);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rdr_newreq: got %s want %s", fmt(w_obs), fmt(e));
    end
    step();
    e = exp_t(1'b0, 32'h204, 1'b0, 32'h0, NOP);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rdr_wait: got %s want %s", fmt(w_obs), fmt(e));
    end
    step();
    e = exp_t(1'b1, 32'h204, 1'b1, 32'h200, 32'hA5A5_0200);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rdr_arrive: got %s want %s", fmt(w_obs), fmt(e));
    end
  endtask

  task automatic test_redirect_stall();
    logic [97:0] e;
    apply_reset();
    step();
    step();
    e = exp_t(1'b1, 32'h4, 1'b1, 32'h0, 32'hA5A5_0000);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rds_pre: got %s want %s", fmt(w_obs), fmt(e));
    end
    // redirect beats stall; no ready, so REQ stays and retargets
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    imem_req_ready = 1'b0;
    step();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    e = exp_t(1'b1, 32'h300, 1'b0, 32'h0, NOP);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rds_flush: got %s want %s", fmt(w_obs), fmt(e));
    end
    step();
    e = exp_t(1'b0, 32'h304, 1'b0, 32'h0, NOP);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rds_wait: got %s want %s", fmt(w_obs), fmt(e));
    end
    step();
    e = exp_t(1'b1, 32'h304, 1'b1, 32'h300, 32'hA5A5_0300);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rds_arrive: got %s want %s", fmt(w_obs), fmt(e));
    end
  endtask

  task automatic test_reset_in_wait();
    logic [97:0] e;
    apply_reset();
    mem_auto = 1'b0;
    step();
    e = exp_t(1'b0, 32'h4, 1'b0, 32'h0, NOP);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rst_wait_pre: got %s want %s", fmt(w_obs), fmt(e));
    end
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    step();
    e = exp_t(1'b1, 32'h0, 1'b0, 32'h0, NOP);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rst_wait_reset: got %s want %s", fmt(w_obs), fmt(e));
    end
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    e = exp_t(1'b1, 32'h0, 1'b0, 32'h0, NOP);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rst_wait_ignore: got %s want %s", fmt(w_obs), fmt(e));
    end
    imem_req_ready = 1'b1;
    step();
    e = exp_t(1'b0, 32'h4, 1'b0, 32'h0, NOP);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rst_wait_req0: got %s want %s", fmt(w_obs), fmt(e));
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    step();
    imem_rsp_valid = 1'b0;
    e = exp_t(1'b1, 32'h4, 1'b1, 32'h0, 32'h1234_5678);
    checks++;
    if (w_obs !== e) begin
      errors++;
      $display("FAIL rst_wait_arrive: got %s want %s", fmt(w_obs), fmt(e));
    end
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mem_auto       = 1'b0;
    rsp_delay      = 0;
    pend           = 1'b0;
    pend_addr      = '0;
    pend_wait      = 0;
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_req_ready();
    test_redirect_stall();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
